// File: rtl/coll_responder.sv
// Collision responder: tracks the last safe player position, lives, post-hit invulnerability and game over.
// Optional sprite blinking during invulnerability is enabled by defining COLL_BLINK_EN.
module coll_responder #(
   parameter int          INIT_LIVES    = 3,
   parameter int          INVULN_FRAMES = 60,
   parameter int          BLINK_FRAMES  = 4,
   parameter logic [19:0] START_X       = 20'd0,
   parameter logic [19:0] START_Y       = 20'd0
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        frame_tick,
   input  logic        sprite_coll,
   input  logic [19:0] sprite_xpos,
   input  logic [19:0] sprite_ypos,
   input  logic        restart,
   output logic [19:0] safe_xpos,
   output logic [19:0] safe_ypos,
   output logic        restore,
   output logic        hit_pulse,
   output logic [2:0]  lives,
   output logic        invuln,
   output logic        game_over,
   output logic        sprite_vis
);

   if (INIT_LIVES < 1 || INIT_LIVES > 7 || INVULN_FRAMES < 1 || INVULN_FRAMES > 255 ||
       BLINK_FRAMES < 1 || BLINK_FRAMES > 255) begin : g_param_check
      $error("coll_responder: parameter out of range");
   end

   typedef enum logic [1:0] {
      ACTIVE = 2'd0,
      INVULN = 2'd1,
      DEAD   = 2'd2
   } state_t;

   localparam logic [2:0] LIVES_INIT = 3'(INIT_LIVES);
   localparam logic [7:0] INV_LOAD   = 8'(INVULN_FRAMES - 1);

   state_t      state_r, state_s;
   logic [2:0]  lives_r, lives_s;
   logic [19:0] safe_x_r, safe_x_s, safe_y_r, safe_y_s;
   logic [7:0]  frame_cnt_r, frame_cnt_s;
   logic        restore_r, restore_s, hit_r, hit_s;
   logic        invuln_r, invuln_s, game_over_r, game_over_s;
`ifdef COLL_BLINK_EN
   localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);
   logic [7:0]  blink_cnt_r, blink_cnt_s;
   logic        vis_r, vis_s;
`endif

   // Next-state and next-output computation; restart outranks frame_tick.
   always_comb begin
      state_s     = state_r;
      lives_s     = lives_r;
      safe_x_s    = safe_x_r;
      safe_y_s    = safe_y_r;
      frame_cnt_s = frame_cnt_r;
      restore_s   = 1'b0;
      hit_s       = 1'b0;
`ifdef COLL_BLINK_EN
      blink_cnt_s = blink_cnt_r;
      vis_s       = vis_r;
`endif
      if (restart) begin
         state_s     = ACTIVE;
         lives_s     = LIVES_INIT;
         safe_x_s    = START_X;
         safe_y_s    = START_Y;
         frame_cnt_s = 8'd0;
         restore_s   = 1'b1;
`ifdef COLL_BLINK_EN
         blink_cnt_s = 8'd0;
         vis_s       = 1'b1;
`endif
      end else if (frame_tick) begin
         case (state_r)
            ACTIVE: begin
               if (!sprite_coll) begin
                  safe_x_s = sprite_xpos;
                  safe_y_s = sprite_ypos;
               end else if (lives_r > 3'd1) begin
                  state_s     = INVULN;
                  lives_s     = lives_r - 3'd1;
                  hit_s       = 1'b1;
                  restore_s   = 1'b1;
                  frame_cnt_s = INV_LOAD;
`ifdef COLL_BLINK_EN
                  blink_cnt_s = 8'd0;
                  vis_s       = 1'b0;
`endif
               end else begin
                  // last life (or none): clamp at zero, no restore
                  state_s = DEAD;
                  lives_s = 3'd0;
                  hit_s   = 1'b1;
               end
            end
            INVULN: begin
               if (frame_cnt_r == 8'd0) begin
                  state_s = ACTIVE;
`ifdef COLL_BLINK_EN
                  blink_cnt_s = 8'd0;
                  vis_s       = 1'b1;
`endif
               end else begin
                  frame_cnt_s = frame_cnt_r - 8'd1;
`ifdef COLL_BLINK_EN
                  if (blink_cnt_r == BLINK_LAST) begin
                     blink_cnt_s = 8'd0;
                     vis_s       = ~vis_r;
                  end else begin
                     blink_cnt_s = blink_cnt_r + 8'd1;
                  end
`endif
               end
            end
            DEAD: begin
               state_s = DEAD;
            end
            default: begin
               state_s = ACTIVE;
            end
         endcase
      end else begin
         state_s = state_r;
      end
      invuln_s    = (state_s == INVULN);
      game_over_s = (state_s == DEAD);
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_r     <= ACTIVE;
         lives_r     <= LIVES_INIT;
         safe_x_r    <= START_X;
         safe_y_r    <= START_Y;
         frame_cnt_r <= 8'd0;
         restore_r   <= 1'b0;
         hit_r       <= 1'b0;
         invuln_r    <= 1'b0;
         game_over_r <= 1'b0;
`ifdef COLL_BLINK_EN
         blink_cnt_r <= 8'd0;
         vis_r       <= 1'b1;
`endif
      end else begin
         state_r     <= state_s;
         lives_r     <= lives_s;
         safe_x_r    <= safe_x_s;
         safe_y_r    <= safe_y_s;
         frame_cnt_r <= frame_cnt_s;
         restore_r   <= restore_s;
         hit_r       <= hit_s;
         invuln_r    <= invuln_s;
         game_over_r <= game_over_s;
`ifdef COLL_BLINK_EN
         blink_cnt_r <= blink_cnt_s;
         vis_r       <= vis_s;
`endif
      end
   end

   assign safe_xpos = safe_x_r;
   assign safe_ypos = safe_y_r;
   assign restore   = restore_r;
   assign hit_pulse = hit_r;
   assign lives     = lives_r;
   assign invuln    = invuln_r;
   assign game_over = game_over_r;
`ifdef COLL_BLINK_EN
   assign sprite_vis = vis_r;
`else
   assign sprite_vis = 1'b1;
`endif

endmodule

// File: tb/tb_coll_responder.sv
// Directed table-driven bench for coll_responder (INVULN_FRAMES=3, BLINK_FRAMES=2, spawn (5,7)).
module tb_coll_responder;

   logic        Clk, Reset_n, frame_tick, sprite_coll, restart;
   logic [19:0] sprite_xpos, sprite_ypos, safe_xpos, safe_ypos;
   logic        restore, hit_pulse, invuln, game_over, sprite_vis;
   logic [2:0]  lives;

   int checks = 0;
   int errors = 0;

   coll_responder #(
      .INIT_LIVES(3), .INVULN_FRAMES(3), .BLINK_FRAMES(2),
      .START_X(20'd5), .START_Y(20'd7)
   ) dut (
      .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .sprite_coll(sprite_coll),
      .sprite_xpos(sprite_xpos), .sprite_ypos(sprite_ypos), .restart(restart),
      .safe_xpos(safe_xpos), .safe_ypos(safe_ypos), .restore(restore), .hit_pulse(hit_pulse),
      .lives(lives), .invuln(invuln), .game_over(game_over), .sprite_vis(sprite_vis)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      logic        tick, coll, rs;
      logic [19:0] x, y;
      logic [19:0] sx, sy;
      logic [2:0]  lv;
      logic        rest, hit, inv, go, vis;
   } vec_t;

   vec_t vecs [23];

   task automatic chk(input string name, input logic [19:0] act, input logic [19:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic exp_vis(input logic blink_val);
`ifdef COLL_BLINK_EN
      return blink_val;
`else
      return 1'b1 | blink_val;
`endif
   endfunction

   task automatic check_all(input string tag, input logic [19:0] sx, input logic [19:0] sy,
                            input logic [2:0] lv, input logic rest, input logic hit,
                            input logic inv, input logic go, input logic vis);
      chk({tag, ".safe_x"}, safe_xpos, sx);
      chk({tag, ".safe_y"}, safe_ypos, sy);
      chk({tag, ".lives"}, 20'(lives), 20'(lv));
      chk({tag, ".restore"}, 20'(restore), 20'(rest));
      chk({tag, ".hit"}, 20'(hit_pulse), 20'(hit));
      chk({tag, ".invuln"}, 20'(invuln), 20'(inv));
      chk({tag, ".game_over"}, 20'(game_over), 20'(go));
      chk({tag, ".vis"}, 20'(sprite_vis), 20'(exp_vis(vis)));
   endtask

   task automatic step(input logic t, input logic c, input logic r, input logic [19:0] x, input logic [19:0] y);
      frame_tick  = t;
      sprite_coll = c;
      restart     = r;
      sprite_xpos = x;
      sprite_ypos = y;
      @(posedge Clk);
      #1;
   endtask

   initial begin
      //          tick  coll  rs    x       y        sx       sy       lv    rest  hit   inv   go    vis
      vecs[0]  = '{1'b0, 1'b1, 1'b0, 20'd100, 20'd200, 20'd5,   20'd7,   3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, 20'd100, 20'd200, 20'd100, 20'd200, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[2]  = '{1'b0, 1'b0, 1'b0, 20'd300, 20'd400, 20'd100, 20'd200, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[3]  = '{1'b1, 1'b1, 1'b0, 20'd300, 20'd400, 20'd100, 20'd200, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 1'b1, 1'b0, 20'd300, 20'd400, 20'd100, 20'd200, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, 1'b1, 1'b0, 20'd300, 20'd400, 20'd100, 20'd200, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[6]  = '{1'b1, 1'b1, 1'b0, 20'd300, 20'd400, 20'd100, 20'd200, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[7]  = '{1'b1, 1'b1, 1'b0, 20'd300, 20'd400, 20'd100, 20'd200, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[8]  = '{1'b1, 1'b1, 1'b0, 20'd300, 20'd400, 20'd100, 20'd200, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[9]  = '{1'b1, 1'b0, 1'b0, 20'd1,   20'd2,   20'd100, 20'd200, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[10] = '{1'b1, 1'b0, 1'b0, 20'd1,   20'd2,   20'd100, 20'd200, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[11] = '{1'b1, 1'b0, 1'b0, 20'd1,   20'd2,   20'd100, 20'd200, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[12] = '{1'b1, 1'b0, 1'b0, 20'd1,   20'd2,   20'd1,   20'd2,   3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[13] = '{1'b1, 1'b1, 1'b0, 20'd1,   20'd2,   20'd1,   20'd2,   3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      vecs[14] = '{1'b0, 1'b1, 1'b0, 20'd1,   20'd2,   20'd1,   20'd2,   3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      vecs[15] = '{1'b1, 1'b1, 1'b0, 20'd1,   20'd2,   20'd1,   20'd2,   3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      vecs[16] = '{1'b1, 1'b0, 1'b0, 20'd9,   20'd9,   20'd1,   20'd2,   3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      vecs[17] = '{1'b1, 1'b1, 1'b1, 20'd9,   20'd9,   20'd5,   20'd7,   3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[18] = '{1'b0, 1'b0, 1'b0, 20'd9,   20'd9,   20'd5,   20'd7,   3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[19] = '{1'b1, 1'b1, 1'b0, 20'd50,  20'd60,  20'd5,   20'd7,   3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[20] = '{1'b1, 1'b1, 1'b0, 20'd50,  20'd60,  20'd5,   20'd7,   3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[21] = '{1'b1, 1'b1, 1'b0, 20'd50,  20'd60,  20'd5,   20'd7,   3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[22] = '{1'b1, 1'b1, 1'b1, 20'd50,  20'd60,  20'd5,   20'd7,   3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

      Reset_n = 1'b1; frame_tick = 1'b0; sprite_coll = 1'b0; restart = 1'b0;
      sprite_xpos = 20'd0; sprite_ypos = 20'd0;
      #2 Reset_n = 1'b0;
      #1;
      check_all("reset", 20'd5, 20'd7, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      repeat (2) @(posedge Clk);
      #1 Reset_n = 1'b1;

      for (int i = 0; i < 23; i++) begin
         step(vecs[i].tick, vecs[i].coll, vecs[i].rs, vecs[i].x, vecs[i].y);
         check_all($sformatf("vec%0d", i), vecs[i].sx, vecs[i].sy, vecs[i].lv, vecs[i].rest,
                   vecs[i].hit, vecs[i].inv, vecs[i].go, vecs[i].vis);
      end

      // hit, then asynchronous reset while the pulses and invulnerability are live
      step(1'b1, 1'b1, 1'b0, 20'd70, 20'd80);
      check_all("prehit", 20'd5, 20'd7, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      #2 Reset_n = 1'b0;
      #1;
      check_all("async_rst", 20'd5, 20'd7, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 20'd70, 20'd80);
      check_all("rst_held", 20'd5, 20'd7, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      Reset_n = 1'b1;
      step(1'b0, 1'b0, 1'b0, 20'd11, 20'd22);
      check_all("post_rst_idle", 20'd5, 20'd7, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 20'd11, 20'd22);
      check_all("post_rst_tick", 20'd11, 20'd22, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/coll_responder.md
COLL_RESPONDER -- requirements
Module: coll_responder

Interface
REQ-001 The block SHALL have parameter INIT_LIVES, default 3, meaning lives loaded at reset or restart (1..7).
REQ-002 The block SHALL have parameter INVULN_FRAMES, default 60, meaning frames of invulnerability after a hit (1..255).
REQ-003 The block SHALL have parameter BLINK_FRAMES, default 4, meaning frames per sprite_vis toggle during invulnerability (1..255).
REQ-004 The block SHALL have parameters START_X and START_Y, each 20 bits, default 0, meaning the player spawn position.
REQ-005 The block SHALL have these ports, in order:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse per video frame.
- sprite_coll  in  1  collision level from the collision detector.
- sprite_xpos  in  20  current player x.
- sprite_ypos  in  20  current player y.
- restart  in  1  one-cycle restart request.
- safe_xpos  out  20  last collision-free x.
- safe_ypos  out  20  last collision-free y.
- restore  out  1  one-cycle pulse: the mover loads safe_xpos/safe_ypos.
- hit_pulse  out  1  one-cycle pulse per counted hit.
- lives  out  3  remaining lives.
- invuln  out  1  high while in INVULN.
- game_over  out  1  high while in DEAD.
- sprite_vis  out  1  sprite draw enable.

Function
REQ-006 The block SHALL implement states ACTIVE, INVULN and DEAD, and all outputs SHALL be registered.
REQ-007 sprite_coll SHALL be sampled only in cycles where frame_tick=1; sprite_coll SHALL be ignored in all other cycles.
REQ-008 In ACTIVE, on a frame_tick with sprite_coll=0, safe_xpos/safe_ypos SHALL load sprite_xpos/sprite_ypos.
REQ-009 In ACTIVE, on a frame_tick with sprite_coll=1 and lives>1, the block SHALL, in the next cycle:
- decrement lives;
- pulse hit_pulse and restore;
- load the frame counter with INVULN_FRAMES-1;
- enter INVULN.
REQ-010 In ACTIVE, on a frame_tick with sprite_coll=1 and lives=1, the block SHALL, in the next cycle:
- set lives=0;
- pulse hit_pulse;
- enter DEAD;
- assert game_over;
- leave restore low.
REQ-011 In INVULN, collisions SHALL be ignored and safe_xpos/safe_ypos SHALL hold.
REQ-012 In INVULN, each frame_tick SHALL decrement the frame counter; a frame_tick when the counter is 0 SHALL return the block to ACTIVE.
REQ-013 In DEAD, all outputs SHALL hold and frame_tick SHALL have no effect.
REQ-014 restart=1 in any state SHALL have priority over frame_tick, and in the next cycle SHALL:
- set lives=INIT_LIVES;
- set safe_xpos/safe_ypos to START_X/START_Y;
- pulse restore;
- clear game_over;
- enter ACTIVE.
REQ-015 hit_pulse and restore SHALL each be high for exactly one cycle per event.
REQ-016 lives SHALL never underflow below 0.
REQ-017 The frame counter SHALL be 8 bits wide.
REQ-018 invuln SHALL equal 1 exactly while the state is INVULN.

Reset
REQ-019 Reset_n=0 SHALL asynchronously force the following, independent of Clk:
- state ACTIVE; lives=INIT_LIVES;
- safe_xpos/safe_ypos = START_X/START_Y;
- counters 0;
- restore, hit_pulse, invuln and game_over = 0;
- sprite_vis=1.
REQ-020 Reset asserted mid-INVULN or in DEAD SHALL abort that state with no pulse emitted.
REQ-021 The first sampling after reset SHALL occur on the first frame_tick after Reset_n deasserts.

Configuration
REQ-022 With macro COLL_BLINK_EN defined, sprite_vis SHALL be 1 outside INVULN.
REQ-023 With COLL_BLINK_EN defined, sprite_vis SHALL go to 0 on entry to INVULN.
REQ-024 With COLL_BLINK_EN defined, during INVULN sprite_vis SHALL toggle after every BLINK_FRAMES frame_ticks.
REQ-025 With COLL_BLINK_EN defined, sprite_vis SHALL return to 1 on exit from INVULN.
REQ-026 Without COLL_BLINK_EN, sprite_vis SHALL be constant 1 and no blink counter SHALL be instantiated.

Verification
REQ-027 The bench SHALL cover a safe track: sprite_coll=0, pos (100,200) on a tick -> safe=(100,200), lives=3, no pulses.
REQ-028 The bench SHALL cover a hit: sprite_coll=1 on a tick -> one cycle later hit_pulse=restore=1 for 1 cycle, lives=2, invuln=1, safe unchanged.
REQ-029 The bench SHALL cover invulnerability with INVULN_FRAMES=3: sprite_coll held 1 -> no hit for 3 ticks, then ACTIVE; the next tick hits and lives=1.
REQ-030 The bench SHALL cover the last life: lives=1 and coll on a tick -> lives=0, game_over=1, restore=0; further ticks cause no change.
REQ-031 The bench SHALL cover restart together with a tick in DEAD -> lives=3, safe=(START_X,START_Y), restore pulse, game_over=0.
REQ-032 The bench SHALL cover blink with COLL_BLINK_EN and BLINK_FRAMES=2 -> sprite_vis 0,0,1,1,0... per tick in INVULN; async Reset_n low mid-INVULN -> invuln=0 and sprite_vis=1 immediately.
